// File: rtl/alu_execute_stage.sv
// Execute wrapper around the external ArithmeticLogicUnit: a four-state
// sequencer with a private register file and an architectural flags register.

package InstructionSetPkg;
  localparam int DataWidth      = 16;
  localparam int ImmediateWidth = 8;

  typedef enum logic [3:0] {
    MOVE = 4'd0,
    LIL  = 4'd1,
    LIH  = 4'd2,
    ADC  = 4'd3,
    ROL  = 4'd4,
    ADD  = 4'd5,
    SUB  = 4'd6,
    AND  = 4'd7,
    OR   = 4'd8,
    XOR  = 4'd9,
    ROR  = 4'd10
  } eOperation;

  typedef struct packed {
    logic Overflow;
    logic Negative;
    logic Zero;
    logic Carry;
  } sFlags;
endpackage

module alu_execute_stage
  import InstructionSetPkg::*;
#(
  parameter int RegAddrWidth = 4
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      IssueValid,
  output logic                      IssueReady,
  input  eOperation                 IssueOp,
  input  logic [RegAddrWidth-1:0]   IssueSrc,
  input  logic [RegAddrWidth-1:0]   IssueDest,
  input  logic [ImmediateWidth-1:0] IssueImm,
  output eOperation                 AluOperation,
  output sFlags                     AluInFlags,
  output logic [DataWidth-1:0]      AluInSrc,
  output logic [DataWidth-1:0]      AluInDest,
  output logic [ImmediateWidth-1:0] AluInImm,
  input  logic [DataWidth-1:0]      AluOutDest,
  input  sFlags                     AluOutFlags,
  output sFlags                     Flags,
  output logic                      DoneValid,
  output logic [RegAddrWidth-1:0]   DoneDest,
  output logic [DataWidth-1:0]      DoneData,
  input  logic [RegAddrWidth-1:0]   DbgAddr,
  output logic [DataWidth-1:0]      DbgData
);

  localparam int NumRegs = 2 ** RegAddrWidth;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] EXEC  = 2'd2;
  localparam logic [1:0] WRITE = 2'd3;

  logic [1:0]                state;
  eOperation                 instrOp;
  logic [RegAddrWidth-1:0]   instrSrc;
  logic [RegAddrWidth-1:0]   instrDest;
  logic [ImmediateWidth-1:0] instrImm;
  logic [DataWidth-1:0]      resultData;
  sFlags                     resultFlags;
  logic [DataWidth-1:0]      regs [NumRegs];

  assign IssueReady = (state == IDLE);
  assign DbgData    = regs[DbgAddr];

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (IssueValid) state <= READ;
        READ:    state <= EXEC;
        EXEC:    state <= WRITE;
        WRITE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      instrOp   <= MOVE;
      instrSrc  <= '0;
      instrDest <= '0;
      instrImm  <= '0;
    end else if (state == IDLE && IssueValid) begin
      instrOp   <= IssueOp;
      instrSrc  <= IssueSrc;
      instrDest <= IssueDest;
      instrImm  <= IssueImm;
    end
  end

  // ALU operands are loaded only in READ so they stay frozen through EXEC.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      AluOperation <= MOVE;
      AluInFlags   <= '0;
      AluInSrc     <= '0;
      AluInDest    <= '0;
      AluInImm     <= '0;
    end else if (state == READ) begin
      AluOperation <= instrOp;
      AluInFlags   <= Flags;
      AluInSrc     <= regs[instrSrc];
      AluInDest    <= regs[instrDest];
      AluInImm     <= instrImm;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      resultData  <= '0;
      resultFlags <= '0;
      DoneValid   <= 1'b0;
      DoneDest    <= '0;
      DoneData    <= '0;
    end else begin
      DoneValid <= (state == EXEC);
      if (state == EXEC) begin
        resultData  <= AluOutDest;
        resultFlags <= AluOutFlags;
        DoneDest    <= instrDest;
        DoneData    <= AluOutDest;
      end
    end
  end

  // An asynchronous reset during WRITE wipes everything before the commit edge.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NumRegs; i++) regs[i] <= '0;
      Flags <= '0;
    end else if (state == WRITE) begin
      regs[instrDest] <= resultData;
      Flags           <= resultFlags;
    end
  end

endmodule

// File: tb/tb_alu_execute_stage.sv
// Scoreboard bench for alu_execute_stage with a small behavioural ALU
// closing the loop between the Alu* outputs and the AluOut* inputs.

module tb_alu_execute_stage;
  import InstructionSetPkg::*;

  typedef struct {
    logic [3:0]  dest;
    logic [15:0] data;
    logic [3:0]  flags;
  } expT;

  logic        Clock;
  logic        Reset;
  logic        IssueValid;
  logic        IssueReady;
  eOperation   IssueOp;
  logic [3:0]  IssueSrc;
  logic [3:0]  IssueDest;
  logic [7:0]  IssueImm;
  eOperation   AluOperation;
  sFlags       AluInFlags;
  logic [15:0] AluInSrc;
  logic [15:0] AluInDest;
  logic [7:0]  AluInImm;
  logic [15:0] AluOutDest;
  sFlags       AluOutFlags;
  sFlags       Flags;
  logic        DoneValid;
  logic [3:0]  DoneDest;
  logic [15:0] DoneData;
  logic [3:0]  DbgAddr;
  logic [15:0] DbgData;

  int  testsRun;
  int  testsFailed;
  expT expQ[$];
  bit  flagsPending;
  logic [3:0] pendingFlags;

  alu_execute_stage #(.RegAddrWidth(4)) dut (
    .Clock(Clock), .Reset(Reset),
    .IssueValid(IssueValid), .IssueReady(IssueReady),
    .IssueOp(IssueOp), .IssueSrc(IssueSrc), .IssueDest(IssueDest), .IssueImm(IssueImm),
    .AluOperation(AluOperation), .AluInFlags(AluInFlags),
    .AluInSrc(AluInSrc), .AluInDest(AluInDest), .AluInImm(AluInImm),
    .AluOutDest(AluOutDest), .AluOutFlags(AluOutFlags),
    .Flags(Flags), .DoneValid(DoneValid), .DoneDest(DoneDest), .DoneData(DoneData),
    .DbgAddr(DbgAddr), .DbgData(DbgData)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Behavioural ALU: only Carry and Zero are produced, undefined ops give 0.
  logic [16:0] aluSum;
  always_comb begin
    AluOutDest  = '0;
    AluOutFlags = AluInFlags;
    aluSum      = '0;
    case (AluOperation)
      MOVE: AluOutDest = AluInSrc;
      LIL:  AluOutDest = {AluInDest[15:8], AluInImm};
      LIH:  AluOutDest = {AluInImm, AluInDest[7:0]};
      ADC: begin
        aluSum = {1'b0, AluInDest} + {1'b0, AluInSrc} + {16'd0, AluInFlags.Carry};
        AluOutDest        = aluSum[15:0];
        AluOutFlags.Carry = aluSum[16];
        AluOutFlags.Zero  = (aluSum[15:0] == 16'd0);
      end
      ROL: begin
        AluOutDest        = {AluInSrc[14:0], AluInFlags.Carry};
        AluOutFlags.Carry = AluInSrc[15];
        AluOutFlags.Zero  = ({AluInSrc[14:0], AluInFlags.Carry} == 16'd0);
      end
      default: AluOutDest = '0;
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkReg(input logic [3:0] addr, input logic [15:0] expected, input string name);
    DbgAddr = addr;
    #1;
    checkOutput(name, {16'd0, DbgData}, {16'd0, expected});
  endtask

  task automatic applyStimulus(input eOperation op, input logic [3:0] src, input logic [3:0] dest,
                               input logic [7:0] imm, input bit push,
                               input logic [15:0] expData, input logic [3:0] expFlags);
    int waited;
    expT e;
    waited = 0;
    @(negedge Clock);
    while (!IssueReady && waited < 20) begin
      @(negedge Clock);
      waited++;
    end
    if (!IssueReady) checkOutput("issue_ready_timeout", 32'(IssueReady), 32'd1);
    IssueOp    = op;
    IssueSrc   = src;
    IssueDest  = dest;
    IssueImm   = imm;
    IssueValid = 1'b1;
    if (push) begin
      e.dest = dest; e.data = expData; e.flags = expFlags;
      expQ.push_back(e);
    end
    @(posedge Clock);
    #1 IssueValid = 1'b0;
  endtask

  // Monitor: pops one expectation per DoneValid and checks Flags one cycle later.
  always @(negedge Clock) begin
    expT e;
    if (flagsPending) begin
      checkOutput("flags_after_write", {28'd0, Flags}, {28'd0, pendingFlags});
      flagsPending = 1'b0;
    end
    if (DoneValid) begin
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL done_unexpected: got dest %0d data 0x%0h, expected no writeback", DoneDest, DoneData);
      end else begin
        e = expQ.pop_front();
        checkOutput("done_dest", {28'd0, DoneDest}, {28'd0, e.dest});
        checkOutput("done_data", {16'd0, DoneData}, {16'd0, e.data});
        pendingFlags = e.flags;
        flagsPending = 1'b1;
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    testsRun = 0; testsFailed = 0; flagsPending = 1'b0; pendingFlags = '0;
    Reset = 1'b0; IssueValid = 1'b0; IssueOp = MOVE;
    IssueSrc = '0; IssueDest = '0; IssueImm = '0; DbgAddr = '0;

    // Reset asserted mid-cycle takes effect immediately.
    #7 Reset = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) checkReg(4'(i), 16'h0000, "reset_reg");
    checkOutput("reset_flags", {28'd0, Flags}, 32'd0);
    checkOutput("reset_done_valid", 32'(DoneValid), 32'd0);
    @(posedge Clock);
    #1 Reset = 1'b0;
    checkOutput("ready_after_reset", 32'(IssueReady), 32'd1);

    // LIL R1, 5: exact pulse timing.
    DbgAddr = 4'd1;
    applyStimulus(LIL, 4'd0, 4'd1, 8'h05, 1'b1, 16'h0005, 4'b0000);
    for (int c = 1; c <= 4; c++) begin
      @(negedge Clock);
      checkOutput($sformatf("lil_done_valid_c%0d", c), 32'(DoneValid), (c == 3) ? 32'd1 : 32'd0);
      checkOutput($sformatf("lil_ready_c%0d", c), 32'(IssueReady), (c == 4) ? 32'd1 : 32'd0);
    end
    checkOutput("lil_r1", {16'd0, DbgData}, 32'h0005);

    // Preload R2 = FFFF, R1 = 0001, then ADC R2 += R1 wraps with Carry and Zero.
    applyStimulus(LIL, 4'd0, 4'd2, 8'hFF, 1'b1, 16'h00FF, 4'b0000);
    applyStimulus(LIH, 4'd0, 4'd2, 8'hFF, 1'b1, 16'hFFFF, 4'b0000);
    applyStimulus(LIL, 4'd0, 4'd1, 8'h01, 1'b1, 16'h0001, 4'b0000);
    applyStimulus(ADC, 4'd1, 4'd2, 8'h00, 1'b1, 16'h0000, 4'b0011);

    // ROL R3 <- R2 must see the Carry produced by the ADC.
    applyStimulus(ROL, 4'd2, 4'd3, 8'h00, 1'b1, 16'h0001, 4'b0000);
    @(negedge Clock);
    @(negedge Clock);
    checkOutput("rol_in_carry", 32'(AluInFlags.Carry), 32'd1);
    checkOutput("rol_in_src", {16'd0, AluInSrc}, 32'h0000);
    checkOutput("rol_operation", {28'd0, AluOperation}, {28'd0, ROL});
    @(negedge Clock);
    @(negedge Clock);
    checkReg(4'd3, 16'h0001, "rol_r3");
    checkReg(4'd2, 16'h0000, "adc_r2");

    // Back-to-back with IssueValid held: accepts only every fourth edge.
    for (int k = 0; k < 12; k++) begin
      expT e;
      @(negedge Clock);
      checkOutput($sformatf("stream_ready_k%0d", k), 32'(IssueReady), (k % 4 == 0) ? 32'd1 : 32'd0);
      IssueValid = 1'b1;
      if (k == 0) begin
        IssueOp = MOVE; IssueSrc = 4'd1; IssueDest = 4'd5; IssueImm = 8'h00;
        e.dest = 4'd5; e.data = 16'h0001; e.flags = 4'b0000; expQ.push_back(e);
      end else if (k == 4) begin
        IssueOp = ADC; IssueSrc = 4'd2; IssueDest = 4'd2; IssueImm = 8'h00;
        e.dest = 4'd2; e.data = 16'h0000; e.flags = 4'b0010; expQ.push_back(e);
      end else if (k == 8) begin
        IssueOp = eOperation'(4'hF); IssueSrc = 4'd1; IssueDest = 4'd6; IssueImm = 8'h77;
        e.dest = 4'd6; e.data = 16'h0000; e.flags = 4'b0010; expQ.push_back(e);
      end else begin
        IssueOp = LIL; IssueSrc = 4'd3; IssueDest = 4'd1; IssueImm = 8'hAA;
      end
      @(posedge Clock);
    end
    #1 IssueValid = 1'b0;
    @(negedge Clock);
    checkReg(4'd1, 16'h0001, "stream_r1_untouched");
    checkReg(4'd5, 16'h0001, "stream_r5");

    // MOVE R4 <- R4 aborted by reset during EXEC.
    applyStimulus(LIL, 4'd0, 4'd4, 8'h34, 1'b1, 16'h0034, 4'b0010);
    applyStimulus(LIH, 4'd0, 4'd4, 8'h12, 1'b1, 16'h1234, 4'b0010);
    applyStimulus(MOVE, 4'd4, 4'd4, 8'h00, 1'b0, 16'h0000, 4'b0000);
    @(negedge Clock);
    @(negedge Clock);
    checkOutput("move_in_src", {16'd0, AluInSrc}, 32'h1234);
    checkOutput("move_in_dest", {16'd0, AluInDest}, 32'h1234);
    Reset = 1'b1;
    #1;
    checkReg(4'd4, 16'h0000, "abort_r4");
    checkOutput("abort_flags", {28'd0, Flags}, 32'd0);
    checkOutput("abort_done_valid", 32'(DoneValid), 32'd0);
    @(posedge Clock);
    #1 Reset = 1'b0;
    checkOutput("abort_ready", 32'(IssueReady), 32'd1);
    repeat (4) @(negedge Clock);
    checkOutput("abort_idle", 32'(IssueReady), 32'd1);
    checkReg(4'd4, 16'h0000, "abort_r4_later");
    checkOutput("queue_empty", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/alu_execute_stage.md
# alu_execute_stage

Sequential execute wrapper that sits directly around `ArithmeticLogicUnit`. It accepts one decoded instruction at a time through a valid/ready handshake and reads the source and destination operands from an internal register file. It drives the ALU inputs from registered values, then writes the ALU result back to the register file and the architectural flags register. The stage is the ALU's immediate upstream producer and downstream consumer; the ALU itself stays a separate, unmodified instance outside this block.

## Interface
- `RegAddrWidth`, default 4: register-file address width, giving 2**RegAddrWidth registers of `DataWidth` bits.
- `DataWidth` and `ImmediateWidth` come from `InstructionSetPkg`. They are not redeclared here.

Ports:
- `Clock`  in  1: single clock; all state updates on the rising edge.
- `Reset`  in  1: asynchronous, active-high.
- `IssueValid`  in  1: an instruction is presented.
- `IssueReady`  out  1: the stage can accept an instruction.
- `IssueOp`  in  eOperation: opcode.
- `IssueSrc`  in  RegAddrWidth: source register index.
- `IssueDest`  in  RegAddrWidth: destination register index.
- `IssueImm`  in  ImmediateWidth: immediate field.
- `AluOperation`  out  eOperation: to ALU `Operation`.
- `AluInFlags`  out  sFlags: to ALU `InFlags`.
- `AluInSrc`  out  DataWidth: to ALU `InSrc`.
- `AluInDest`  out  DataWidth: to ALU `InDest`.
- `AluInImm`  out  ImmediateWidth: to ALU `InImm`.
- `AluOutDest`  in  DataWidth: from ALU `OutDest`.
- `AluOutFlags`  in  sFlags: from ALU `OutFlags`.
- `Flags`  out  sFlags: architectural flags register.
- `DoneValid`  out  1: one-cycle pulse when writeback commits.
- `DoneDest`  out  RegAddrWidth: register written.
- `DoneData`  out  DataWidth: value written.
- `DbgAddr`  in  RegAddrWidth: debug read address.
- `DbgData`  out  DataWidth: combinational read of `regs[DbgAddr]`.

## Operation
- FSM states: IDLE, READ, EXEC, WRITE.
  - IDLE goes to READ on `IssueValid && IssueReady`.
  - READ, EXEC and WRITE each advance unconditionally: READ→EXEC→WRITE→IDLE.
- `IssueReady` = (state == IDLE). It is registered-state-derived and has no combinational path from `IssueValid`.
- On accept, latch `IssueOp`, `IssueSrc`, `IssueDest` and `IssueImm` into instruction registers. `Issue*` inputs are ignored outside IDLE.
- READ:
  - Load `AluInSrc` ← `regs[src]` and `AluInDest` ← `regs[dest]`.
  - Load `AluInFlags` ← `Flags`, `AluOperation` ← latched op, `AluInImm` ← latched imm.
  - src == dest is legal; both operands then carry the same value.
- EXEC:
  - The ALU inputs are stable for the whole cycle.
  - At the end of EXEC, capture `AluOutDest` and `AluOutFlags` into result registers.
- WRITE:
  - `regs[dest]` ← result; `Flags` ← captured flags. Both update at the end of WRITE.
  - `DoneValid` = 1, `DoneDest` = dest and `DoneData` = result during WRITE. All three are registered outputs.
- The stage does not interpret opcodes. Every opcode, including one the ALU does not define (result 0, flags passed through), is written back unchanged.
- The `Alu*` outputs hold their last values outside READ/EXEC; they change only in READ.
- There is no special register: index 0 is an ordinary register.
- Flags dependency between instructions is resolved by serialisation. Instruction N+1 reads `Flags` after instruction N's WRITE, so no forwarding is needed.

## Timing
- Latency from the accept edge (cycle 0) to writeback:
  - READ in cycle 1, EXEC in cycle 2, WRITE in cycle 3 with `DoneValid` = 1.
  - The new register and `Flags` values are visible on `DbgData` and `Flags` from cycle 4.
- Throughput: one instruction per 4 cycles. With `IssueValid` held high, the next accept occurs at cycle 4 exactly.
- `IssueReady` is low in cycles 1–3.
- Reset (asynchronous, immediate):
  - State goes to IDLE and all registers, `Flags` and the result registers go to 0.
  - `DoneValid`, `DoneDest`, `DoneData`, `AluInSrc`, `AluInDest`, `AluInImm` and `AluInFlags` go to 0.
  - `AluOperation` goes to the enum value encoded 0.
  - `IssueReady` = 1 once `Reset` deasserts.
- Reset mid-instruction (READ, EXEC or WRITE): the instruction is aborted. No register or flags write is committed, and `DoneValid` stays 0.
- Release of `Reset` is synchronous to `Clock` by the surrounding design. An accept is possible on the first edge after release.

## Test plan
All scenarios use DataWidth = 16 and RegAddrWidth = 4.

1. Assert `Reset` mid-cycle → immediately all `DbgData` reads return 0, `Flags` = 0 and `DoneValid` = 0; after release `IssueReady` = 1.
2. Issue LIL, dest = R1, imm = 5 at cycle 0 → `DoneValid` pulses in cycle 3 only, with `DoneDest` = 1 and `DoneData` = 0x0005; from cycle 4, `DbgData(R1)` = 0x0005.
3. Preload R2 = 0xFFFF and R1 = 0x0001 with Carry = 0, then issue ADC, dest = R2, src = R1 → R2 = 0x0000, `Flags.Carry` = 1 and `Flags.Zero` = 1.
4. Follow scenario 3 immediately with ROL, dest = R3, src = R2 → the ALU sees `InFlags.Carry` = 1 and R3 = 0x0001, proving the serialised flags dependency.
5. Hold `IssueValid` high for three instructions → accepts occur at cycles 0, 4 and 8; `IssueReady` is low in cycles 1–3 and 5–7; the `Issue*` changes made while `IssueReady` is low are ignored.
6. Issue MOVE R4 ← R4 (R4 = 0x1234) and assert `Reset` during EXEC → no `DoneValid`, R4 = 0 from the reset, and the FSM is in IDLE.
